// File: rtl/pa_soc_timer.sv
// Prescaled compare-match timer slave: CTRL/PRESCALE/COUNT/COMPARE/STATUS registers, level IRQ.
// Optional input capture on offset 5 when TIMER_CAPTURE_EN is defined.
module pa_soc_timer #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int PSC_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [ADDR_BUS_WIDTH-1:0] addr_i,
  input  logic [DATA_BUS_WIDTH-1:0] data_i,
  output logic [DATA_BUS_WIDTH-1:0] data_o,
  input  logic                      we_i,
  input  logic                      rd_i,
`ifdef TIMER_CAPTURE_EN
  input  logic                      capture_i,
`endif
  output logic                      irq_o
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  localparam logic [2:0] OFF_CAPTURE  = 3'd5;

  logic                 r_en;
  logic                 r_ie;
  logic                 r_oneshot;
  logic [PSC_WIDTH-1:0] r_psc;
  logic [PSC_WIDTH-1:0] r_psc_cnt;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_compare;
  logic                 r_match;

  logic [2:0] w_off;
  logic       w_wr_ctrl;
  logic       w_wr_psc;
  logic       w_wr_count;
  logic       w_wr_compare;
  logic       w_wr_status;
  logic       w_en_clear;
  logic       w_tick;
  logic       w_tick_act;
  logic       w_hit;
  logic       w_unused;

  assign w_off        = addr_i[4:2];
  assign w_wr_ctrl    = we_i && (w_off == OFF_CTRL);
  assign w_wr_psc     = we_i && (w_off == OFF_PRESCALE);
  assign w_wr_count   = we_i && (w_off == OFF_COUNT);
  assign w_wr_compare = we_i && (w_off == OFF_COMPARE);
  assign w_wr_status  = we_i && (w_off == OFF_STATUS);
  assign w_en_clear   = w_wr_ctrl && !data_i[0];
  assign w_unused     = ^{addr_i, data_i};

  // A tick is consumed by a COUNT write or by software disabling the timer.
  assign w_tick     = r_en && (r_psc_cnt == r_psc);
  assign w_tick_act = w_tick && !w_wr_count && !w_en_clear;
  assign w_hit      = w_tick_act && (r_count == r_compare);

  // Clearing when psc_cnt >= new PRESCALE keeps the next compare reachable without a full wrap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_psc_cnt <= '0;
    end else if (!r_en || w_en_clear || w_wr_count || w_tick) begin
      r_psc_cnt <= '0;
    end else if (w_wr_psc && (r_psc_cnt >= data_i[PSC_WIDTH-1:0])) begin
      r_psc_cnt <= '0;
    end else begin
      r_psc_cnt <= r_psc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_en      <= 1'b0;
      r_ie      <= 1'b0;
      r_oneshot <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en      <= data_i[0];
      r_ie      <= data_i[1];
      r_oneshot <= data_i[2];
    end else if (w_hit && r_oneshot) begin
      r_en <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_psc     <= '0;
      r_compare <= '1;
    end else begin
      if (w_wr_psc)     r_psc     <= data_i[PSC_WIDTH-1:0];
      if (w_wr_compare) r_compare <= data_i[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
    end else if (w_wr_count) begin
      r_count <= data_i[CNT_WIDTH-1:0];
    end else if (w_tick_act) begin
      r_count <= w_hit ? '0 : r_count + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_match <= 1'b0;
    end else if (w_hit) begin
      r_match <= 1'b1;
    end else if (w_wr_status && data_i[0]) begin
      r_match <= 1'b0;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic                 r_cap_s1;
  logic                 r_cap_s2;
  logic                 r_cap_s3;
  logic [CNT_WIDTH-1:0] r_capture;
  logic                 r_capf;
  logic                 w_cap_edge;

  assign w_cap_edge = r_cap_s2 && !r_cap_s3;

  // Two flops synchronise the pin; the third only remembers the previous level for edge detect.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cap_s1 <= 1'b0;
      r_cap_s2 <= 1'b0;
      r_cap_s3 <= 1'b0;
    end else begin
      r_cap_s1 <= capture_i;
      r_cap_s2 <= r_cap_s1;
      r_cap_s3 <= r_cap_s2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_capture <= '0;
      r_capf    <= 1'b0;
    end else if (w_cap_edge) begin
      r_capture <= r_count;
      r_capf    <= 1'b1;
    end else if (w_wr_status && data_i[1]) begin
      r_capf <= 1'b0;
    end
  end

  assign irq_o = (r_match || r_capf) && r_ie;
`else
  assign irq_o = r_match && r_ie;
`endif

  always_comb begin
    data_o = '0;
    if (rd_i) begin
      case (w_off)
        OFF_CTRL:     data_o[2:0] = {r_oneshot, r_ie, r_en};
        OFF_PRESCALE: data_o[PSC_WIDTH-1:0] = r_psc;
        OFF_COUNT:    data_o[CNT_WIDTH-1:0] = r_count;
        OFF_COMPARE:  data_o[CNT_WIDTH-1:0] = r_compare;
        OFF_STATUS: begin
          data_o[0] = r_match;
`ifdef TIMER_CAPTURE_EN
          data_o[1] = r_capf;
`endif
        end
`ifdef TIMER_CAPTURE_EN
        OFF_CAPTURE:  data_o[CNT_WIDTH-1:0] = r_capture;
`endif
        default:      data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pa_soc_timer.sv
// Scoreboard bench for pa_soc_timer: stimulus pushes expected read data and irq level into a
// queue, a negedge monitor pops and compares whenever a sample is requested.
module tb_pa_soc_timer;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  localparam logic [2:0] OFF_CAPTURE  = 3'd5;

  typedef struct {
    logic [31:0] expData;
    logic        expIrq;
    string       name;
  } expEntry_t;

  logic        clk;
  logic        rstN;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        we;
  logic        rd;
  logic        irq;
  logic        captureIn;
  logic        monReq;

  expEntry_t expQ[$];
  int checkCount;
  int passCount;

  // COUNT seen in the cycle after each edge once PRESCALE=3, COMPARE=4 and EN are set
  int periodicCnt [24] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 4,4,4,4, 0,0,0,0};

  pa_soc_timer dut (
    .clk_i     (clk),
    .rst_n_i   (rstN),
    .addr_i    (addr),
    .data_i    (wdata),
    .data_o    (rdata),
    .we_i      (we),
    .rd_i      (rd),
`ifdef TIMER_CAPTURE_EN
    .capture_i (captureIn),
`endif
    .irq_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input expEntry_t e);
    checkCount++;
    if (rdata === e.expData) passCount++;
    else $display("[TB] FAIL %s data_o: got 0x%08h, expected 0x%08h", e.name, rdata, e.expData);
    checkCount++;
    if (irq === e.expIrq) passCount++;
    else $display("[TB] FAIL %s irq_o: got %b, expected %b", e.name, irq, e.expIrq);
  endtask

  always @(negedge clk) begin
    if (monReq) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL monitor: sample requested with empty scoreboard");
      end else begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  function automatic logic [31:0] addrFor(input logic [2:0] off);
    return 32'h2000_0000 | {27'd0, off, 2'b00};
  endfunction

  task automatic writeReg(input logic [2:0] off, input logic [31:0] val);
    addr  = addrFor(off);
    wdata = val;
    we    = 1'b1;
    stepCycle();
    we    = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] off, input logic doRead,
                               input logic [31:0] expData, input logic expIrq,
                               input string name);
    expEntry_t e;
    e.expData = expData;
    e.expIrq  = expIrq;
    e.name    = name;
    addr   = addrFor(off);
    rd     = doRead;
    expQ.push_back(e);
    monReq = 1'b1;
    stepCycle();
    monReq = 1'b0;
    rd     = 1'b0;
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expEntry_t rstEntry;
    checkCount = 0;
    passCount  = 0;
    rstN = 1'b0; we = 1'b0; rd = 1'b0; monReq = 1'b0; captureIn = 1'b0;
    addr = '0; wdata = '0;
    idle(3);
    rstN = 1'b1;
    stepCycle();

    $display("[TB] reset values");
    applyStimulus(OFF_CTRL,     1'b1, 32'h0,         1'b0, "rst CTRL");
    applyStimulus(OFF_PRESCALE, 1'b1, 32'h0,         1'b0, "rst PRESCALE");
    applyStimulus(OFF_COUNT,    1'b1, 32'h0,         1'b0, "rst COUNT");
    applyStimulus(OFF_COMPARE,  1'b1, 32'hFFFF_FFFF, 1'b0, "rst COMPARE");
    applyStimulus(OFF_STATUS,   1'b1, 32'h0,         1'b0, "rst STATUS");

    $display("[TB] periodic mode");
    writeReg(OFF_PRESCALE, 32'd3);
    writeReg(OFF_COMPARE,  32'd4);
    writeReg(OFF_CTRL,     32'h3);
    for (int k = 0; k < 24; k++)
      applyStimulus(OFF_COUNT, 1'b1, periodicCnt[k], (k >= 20),
                    $sformatf("periodic COUNT k=%0d", k));
    applyStimulus(OFF_STATUS, 1'b1, 32'h1, 1'b1, "periodic MATCH");

    $display("[TB] W1C race");
    writeReg(OFF_STATUS, 32'h1);
    applyStimulus(OFF_STATUS, 1'b1, 32'h0, 1'b0, "w1c clear");
    idle(12);
    writeReg(OFF_STATUS, 32'h1);
    applyStimulus(OFF_STATUS, 1'b1, 32'h1, 1'b1, "w1c race set wins");
    writeReg(OFF_STATUS, 32'h1);
    applyStimulus(OFF_STATUS, 1'b1, 32'h0, 1'b0, "w1c later clear");

    $display("[TB] write priority");
    writeReg(OFF_CTRL,   32'h0);
    writeReg(OFF_STATUS, 32'h1);
    writeReg(OFF_COUNT,  32'h0);
    writeReg(OFF_CTRL,   32'h3);
    idle(3);
    writeReg(OFF_COUNT,  32'h100);
    for (int k = 0; k < 4; k++)
      applyStimulus(OFF_COUNT, 1'b1, 32'h100, 1'b0, $sformatf("prio COUNT hold %0d", k));
    applyStimulus(OFF_COUNT, 1'b1, 32'h101, 1'b0, "prio COUNT next tick");
    applyStimulus(OFF_COUNT, 1'b0, 32'h0,   1'b0, "rd_i low");
    applyStimulus(3'd7,      1'b1, 32'h0,   1'b0, "offset 7");
    applyStimulus(3'd6,      1'b1, 32'h0,   1'b0, "offset 6");
`ifndef TIMER_CAPTURE_EN
    applyStimulus(OFF_CAPTURE, 1'b1, 32'h0, 1'b0, "offset 5 absent");
`endif

    $display("[TB] one-shot mode");
    writeReg(OFF_CTRL,     32'h0);
    writeReg(OFF_STATUS,   32'h1);
    writeReg(OFF_COUNT,    32'h0);
    writeReg(OFF_PRESCALE, 32'h0);
    writeReg(OFF_COMPARE,  32'd2);
    writeReg(OFF_CTRL,     32'h7);
    applyStimulus(OFF_COUNT,  1'b1, 32'h0, 1'b0, "oneshot COUNT 0");
    applyStimulus(OFF_COUNT,  1'b1, 32'h1, 1'b0, "oneshot COUNT 1");
    applyStimulus(OFF_COUNT,  1'b1, 32'h2, 1'b0, "oneshot COUNT 2");
    applyStimulus(OFF_COUNT,  1'b1, 32'h0, 1'b1, "oneshot match");
    applyStimulus(OFF_CTRL,   1'b1, 32'h6, 1'b1, "oneshot CTRL");
    applyStimulus(OFF_STATUS, 1'b1, 32'h1, 1'b1, "oneshot STATUS");
    applyStimulus(OFF_COUNT,  1'b1, 32'h0, 1'b1, "oneshot COUNT stays");

    $display("[TB] reset mid-operation");
    writeReg(OFF_PRESCALE, 32'd5);
    writeReg(OFF_COUNT,    32'h10);
    writeReg(OFF_CTRL,     32'h3);
    rstEntry.expData = 32'h0;
    rstEntry.expIrq  = 1'b0;
    rstEntry.name    = "async reset";
    addr   = addrFor(OFF_COUNT);
    rd     = 1'b1;
    expQ.push_back(rstEntry);
    monReq = 1'b1;
    rstN   = 1'b0;
    stepCycle();
    monReq = 1'b0;
    rd     = 1'b0;
    rstN   = 1'b1;
    applyStimulus(OFF_COUNT,    1'b1, 32'h0,         1'b0, "post-rst COUNT");
    applyStimulus(OFF_COMPARE,  1'b1, 32'hFFFF_FFFF, 1'b0, "post-rst COMPARE");
    applyStimulus(OFF_CTRL,     1'b1, 32'h0,         1'b0, "post-rst CTRL");
    applyStimulus(OFF_PRESCALE, 1'b1, 32'h0,         1'b0, "post-rst PRESCALE");

`ifdef TIMER_CAPTURE_EN
    $display("[TB] input capture");
    writeReg(OFF_COUNT, 32'h55);
    writeReg(OFF_CTRL,  32'h3);
    captureIn = 1'b1;
    idle(5);
    captureIn = 1'b0;
    applyStimulus(OFF_CAPTURE, 1'b1, 32'h57, 1'b1, "capture value");
    applyStimulus(OFF_STATUS,  1'b1, 32'h2,  1'b1, "capture CAPF");
`endif

    idle(2);
    if (expQ.size() != 0) begin
      $display("[TB] FAIL scoreboard: %0d entries left, expected 0", expQ.size());
      checkCount += expQ.size();
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
